// File: rtl/song_playback_sequencer.sv
// song_playback_sequencer
//   Walks the note store one address per beat, fetches each 4-bit pitch code
//   (0 = REST, 1..15 = D1..E3) and presents it to the tone generator for one beat.
//   A note occupies FETCH (1) + LOAD (1) + HOLD (beat_ticks) cycles.
//   Optional feature macro: SOLO_LOOP_EN -- when defined, playback wraps from the
//   last address back to address 0 instead of finishing through DONE.
//   Store read handshake: rd_en is a one-cycle strobe; rd_data is taken exactly
//   one cycle later (in LOAD) with no back-pressure.
//   dbg_state exposes the FSM state encoding (IDLE=0 FETCH=1 LOAD=2 HOLD=3 DONE=4).
module song_playback_sequencer #(
  parameter int SONG_LEN       = 256,
  parameter int ADDR_W         = 8,
  parameter int TICKS_PER_BEAT = 12_500_000,
  parameter int CNT_W          = 24
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              play,
  input  logic              stop,
  input  logic              pause,
  input  logic [1:0]        tempo_sel,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [3:0]        rd_data,
  output logic [3:0]        note_out,
  output logic              note_on,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);
  localparam logic [CNT_W-1:0]  TICKS     = CNT_W'(TICKS_PER_BEAT);

  state_t             state;
  logic [CNT_W-1:0]   beat_cnt;
  logic [CNT_W-1:0]   ticks_shifted;
  logic [CNT_W-1:0]   beat_last;

  // Beat length for the selected tempo, clamped to at least one cycle; counter loads length-1.
  always_comb begin
    ticks_shifted = TICKS >> tempo_sel;
    beat_last     = '0;
    if (ticks_shifted != '0) begin
      beat_last = ticks_shifted - CNT_W'(1);
    end
  end

  // Playback FSM: stop aborts from any active state; pause only freezes the HOLD countdown.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      note_out <= 4'd0;
      done     <= 1'b0;
      beat_cnt <= '0;
    end else begin
      rd_en <= 1'b0;
      done  <= 1'b0;
      if (stop && (state != S_IDLE)) begin
        state    <= S_IDLE;
        note_out <= 4'd0;
        rd_addr  <= '0;
        beat_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (play && !stop) begin
              state   <= S_FETCH;
              rd_addr <= '0;
              rd_en   <= 1'b1;
            end
          end
          S_FETCH: begin
            state <= S_LOAD;
          end
          S_LOAD: begin
            // note_out changes only here, so the previous pitch sounds through FETCH/LOAD.
            note_out <= rd_data;
            beat_cnt <= beat_last;
            state    <= S_HOLD;
          end
          S_HOLD: begin
            if (!pause) begin
              if (beat_cnt == '0) begin
                if (rd_addr == LAST_ADDR) begin
`ifdef SOLO_LOOP_EN
                  done    <= 1'b1;
                  rd_addr <= '0;
                  rd_en   <= 1'b1;
                  state   <= S_FETCH;
`else
                  done     <= 1'b1;
                  note_out <= 4'd0;
                  rd_addr  <= '0;
                  state    <= S_DONE;
`endif
                end else begin
                  rd_addr <= rd_addr + ADDR_W'(1);
                  rd_en   <= 1'b1;
                  state   <= S_FETCH;
                end
              end else begin
                beat_cnt <= beat_cnt - CNT_W'(1);
              end
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign busy      = (state != S_IDLE);
  assign note_on   = (state == S_HOLD) && !pause && (note_out != 4'd0);
  assign dbg_state = state;

endmodule

// File: tb/tb_song_playback_sequencer.sv
// tb_song_playback_sequencer
//   Small song (4 notes, 4 ticks per beat, store = {15,0,14,2}). Each started song
//   pushes its expected pitches and hold lengths; a negedge monitor pops them on
//   every HOLD entry / exit. Directed sections cover reset, tempo, pause, stop and
//   the SOLO_LOOP_EN repeat behaviour.
module tb_song_playback_sequencer;

  localparam int SONG_LEN = 4;
  localparam int ADDR_W   = 2;
  localparam int TICKS    = 4;
  localparam int CNT_W    = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Clock / reset
  logic              CLOCK_50 = 1'b0;
  logic              reset_n  = 1'b1;
  logic              play     = 1'b0;
  logic              stop     = 1'b0;
  logic              pause    = 1'b0;
  logic [1:0]        tempo_sel = 2'd0;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [3:0]        rd_data = 4'd0;
  logic [3:0]        note_out;
  logic              note_on;
  logic              busy;
  logic              done;
  logic [2:0]        dbg_state;

  always #5 CLOCK_50 = ~CLOCK_50;

  song_playback_sequencer #(
    .SONG_LEN(SONG_LEN), .ADDR_W(ADDR_W), .TICKS_PER_BEAT(TICKS), .CNT_W(CNT_W)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .play(play), .stop(stop), .pause(pause),
    .tempo_sel(tempo_sel), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .note_out(note_out), .note_on(note_on), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // Note store model: registered read, data one cycle after rd_en.
  logic [3:0] store [SONG_LEN] = '{4'd15, 4'd0, 4'd14, 4'd2};
  always @(posedge CLOCK_50) if (rd_en) rd_data <= store[rd_addr];

  // Scoreboard
  logic [3:0] exp_q[$];
  int         exp_len_q[$];
  int         total = 0;
  int         bad = 0;
  int         done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Monitor: pitch on HOLD entry, unpaused hold length on HOLD exit, note_on every cycle.
  logic [2:0] prev_state = 3'd0;
  logic [3:0] cur_note = 4'd0;
  int         hold_cnt = 0;
  always @(negedge CLOCK_50) begin
    if (done) done_cnt++;
    if (dbg_state == ST_HOLD && prev_state != ST_HOLD) begin
      hold_cnt = 0;
      if (exp_q.size() == 0) check("note_unexpected", exp_q.size(), 1);
      else begin
        cur_note = exp_q.pop_front();
        check("note", note_out, cur_note);
      end
    end
    if (dbg_state == ST_HOLD && !pause) hold_cnt++;
    if (prev_state == ST_HOLD && (dbg_state == ST_FETCH || dbg_state == ST_DONE)) begin
      if (exp_len_q.size() == 0) check("len_unexpected", exp_len_q.size(), 1);
      else check("hold_len", hold_cnt, exp_len_q.pop_front());
    end
    check("note_on", note_on, (dbg_state == ST_HOLD) && !pause && (cur_note != 4'd0));
    prev_state = dbg_state;
  end

  // Driver tasks
  task automatic push_song(input int tempo, input int passes);
    int len;
    len = TICKS >> tempo;
    if (len < 1) len = 1;
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < SONG_LEN; i++) begin
        exp_q.push_back(store[i]);
        exp_len_q.push_back(len);
      end
  endtask

  task automatic flush();
    exp_q.delete();
    exp_len_q.delete();
  endtask

  // Returns #1 after the edge that samples play.
  task automatic start_play(input int tempo);
    @(posedge CLOCK_50); #1;
    tempo_sel = 2'(tempo);
    play = 1'b1;
    @(posedge CLOCK_50); #1;
    play = 1'b0;
  endtask

  task automatic wait_hold_note(input logic [3:0] note, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge CLOCK_50);
      n++;
    end while (!(dbg_state == ST_HOLD && note_out == note) && n < 100);
    check({tag, "_state"}, dbg_state, ST_HOLD);
    check({tag, "_note"}, note_out, note);
  endtask

  // Counts negedges until done; single-shot: checks DONE-cycle outputs and return to IDLE.
  task automatic wait_done(input int exp_n, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge CLOCK_50);
      n++;
    end while (!done && n < 200);
    check({tag, "_done_at"}, n, exp_n);
`ifdef SOLO_LOOP_EN
    check({tag, "_loop_rd_en"}, rd_en, 1);
    check({tag, "_loop_addr"}, rd_addr, 0);
    @(posedge CLOCK_50); #1 stop = 1'b1;
    @(posedge CLOCK_50); #1 stop = 1'b0;
    @(negedge CLOCK_50);
    check({tag, "_stop_busy"}, busy, 0);
    flush();
`else
    check({tag, "_done_note"}, note_out, 0);
    check({tag, "_done_addr"}, rd_addr, 0);
    check({tag, "_done_busy"}, busy, 1);
    @(negedge CLOCK_50);
    check({tag, "_done_width"}, done, 0);
    check({tag, "_idle_busy"}, busy, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    int n;
    // Reset state
    #1 reset_n = 1'b0;
    #11;
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_busy", busy, 0);
    check("rst_note", note_out, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_addr", rd_addr, 0);
    check("rst_done", done, 0);
    @(posedge CLOCK_50); #1 reset_n = 1'b1;

    // Async reset in the middle of note 15
    push_song(0, 1);
    start_play(0);
    wait_hold_note(4'd15, "t1");
    check("t1_busy_pre", busy, 1);
    check("t1_on_pre", note_on, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t1_state", dbg_state, ST_IDLE);
    check("t1_note", note_out, 0);
    check("t1_on", note_on, 0);
    check("t1_busy", busy, 0);
    check("t1_rd_en", rd_en, 0);
    check("t1_addr", rd_addr, 0);
    check("t1_done", done, 0);
    flush();
    @(posedge CLOCK_50); #1 reset_n = 1'b1;

    // Full song at tempo 0: period 6, done registered after edge k+24
    d0 = done_cnt;
    push_song(0, 1);
    start_play(0);
    wait_done(25, "t2");
    check("t2_q_empty", exp_q.size(), 0);
    check("t2_done_once", done_cnt - d0, 1);

    // Tempo 2 (1 tick) and tempo 3 (clamped to 1 tick): period 3
    push_song(2, 1);
    start_play(2);
    wait_done(13, "t3a");
    push_song(3, 1);
    start_play(3);
    wait_done(13, "t3b");
    check("t3_q_empty", exp_q.size(), 0);

    // Pause for 10 cycles after 2 HOLD cycles of note 15
    push_song(0, 1);
    start_play(0);
    wait_hold_note(4'd15, "t4");
    @(posedge CLOCK_50); #1;
    @(posedge CLOCK_50); #1 pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLOCK_50);
      check("t4_pause_note", note_out, 15);
      check("t4_pause_on", note_on, 0);
    end
    @(posedge CLOCK_50); #1 pause = 1'b0;
    n = 0;
    do begin
      @(negedge CLOCK_50);
      n++;
    end while (!rd_en && n < 20);
    check("t4_resume_cycles", n, 3);
    check("t4_resume_addr", rd_addr, 1);
    wait_done(18, "t4");

    // Stop during note 14: no done pulse
    d0 = done_cnt;
    push_song(0, 1);
    start_play(0);
    wait_hold_note(4'd14, "t5");
    @(posedge CLOCK_50); #1 stop = 1'b1;
    @(posedge CLOCK_50); #1 stop = 1'b0;
    @(negedge CLOCK_50);
    check("t5_state", dbg_state, ST_IDLE);
    check("t5_note", note_out, 0);
    check("t5_addr", rd_addr, 0);
    check("t5_busy", busy, 0);
    repeat (5) @(negedge CLOCK_50);
    check("t5_no_done", done_cnt - d0, 0);
    flush();

    // play and stop together in IDLE: stays idle
    @(posedge CLOCK_50); #1 play = 1'b1; stop = 1'b1;
    @(posedge CLOCK_50); #1 play = 1'b0; stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLOCK_50);
      check("t5_ps_busy", busy, 0);
      check("t5_ps_rd_en", rd_en, 0);
    end

`ifdef SOLO_LOOP_EN
    // Looping: two identical passes, done between them, then stop
    push_song(0, 2);
    start_play(0);
    n = 0;
    do begin @(negedge CLOCK_50); n++; end while (!done && n < 200);
    check("t6_first_done", n, 25);
    check("t6_rd_en", rd_en, 1);
    check("t6_addr", rd_addr, 0);
    n = 0;
    do begin @(negedge CLOCK_50); n++; end while (!done && n < 200);
    check("t6_second_done", n, 24);
    @(posedge CLOCK_50); #1 stop = 1'b1;
    @(posedge CLOCK_50); #1 stop = 1'b0;
    @(negedge CLOCK_50);
    check("t6_stop_busy", busy, 0);
    check("t6_q_empty", exp_q.size(), 0);
    flush();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
